// File: rtl/ufm_page_fetcher.sv
// Fetches a run of 16-byte UFM pages from the streamer into a local FIFO and
// hands the bytes to user logic over valid/ready, pacing reads by FIFO room.
module ufm_page_fetcher #(
  parameter int BUF_PAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_start,
  input  logic [10:0] req_addr,
  input  logic [11:0] req_pages,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        ufm_start,
  output logic [10:0] ufm_addr,
  input  logic [7:0]  ufm_data,
  input  logic        ufm_data_stb,
  input  logic        ufm_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int DEPTH = 16 * BUF_PAGES;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ROOM = (AW+1)'(DEPTH - 16);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, ISSUE, COLLECT, DRAIN} state_t;

  state_t        state;
  logic [11:0]   pages_left;
  logic [3:0]    byte_cnt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          push;
  logic          push_ok;
  logic          pop;
  logic [AW:0]   count_nxt;
  logic [AW-1:0] head_idx;
  logic [7:0]    head_nxt;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = ufm_data_stb;
  assign push_ok   = push & (count != FULL);
  assign busy      = (state != IDLE);
  // Combinational so the streamer sees the request while it sits idle.
  assign ufm_start = (state == ISSUE) & ufm_ready;

  // Next head entry; bypass the incoming byte when it becomes the head.
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)
      count_nxt = count + (AW+1)'(1);
    else if (!push_ok && pop)
      count_nxt = count - (AW+1)'(1);
    head_idx = pop ? rd_ptr + AW'(1) : rd_ptr;
    head_nxt = (push_ok && (wr_ptr == head_idx)) ? ufm_data : mem[head_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= ufm_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      count <= count_nxt;
      if (count_nxt != '0) out_data <= head_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ufm_addr   <= '0;
      pages_left <= '0;
      byte_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req_start) begin
          if (req_pages == '0) begin
            done <= 1'b1;
          end else begin
            ufm_addr   <= req_addr;
            pages_left <= req_pages;
            state      <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: if (count <= ROOM) state <= ISSUE;
        ISSUE:      if (ufm_ready) state <= COLLECT;
        COLLECT: if (ufm_data_stb) begin
          byte_cnt <= byte_cnt + 4'd1;
          if (byte_cnt == 4'hF) begin
            pages_left <= pages_left - 12'd1;
            ufm_addr   <= ufm_addr + 11'd1;
            state      <= (pages_left > 12'd1) ? WAIT_SPACE : DRAIN;
          end
        end
        // Look at next count so done lands the cycle right after the last pop.
        DRAIN: if (count_nxt == '0) begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ufm_page_fetcher.sv
// Bench for ufm_page_fetcher: streamer model, byte-stream reference queue and
// directed plus randomized fetch runs.
module tb_ufm_page_fetcher;
  localparam int BUF_PAGES = 2;
  localparam int DEPTH     = 16 * BUF_PAGES;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_start = 1'b0;
  logic [10:0] req_addr = '0;
  logic [11:0] req_pages = '0;
  logic        busy, done, overflow, ufm_start;
  logic [10:0] ufm_addr;
  logic [7:0]  ufm_data;
  logic        ufm_data_stb, ufm_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  ufm_page_fetcher #(.BUF_PAGES(BUF_PAGES)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_addr(req_addr),
    .req_pages(req_pages), .busy(busy), .done(done), .overflow(overflow),
    .ufm_start(ufm_start), .ufm_addr(ufm_addr), .ufm_data(ufm_data),
    .ufm_data_stb(ufm_data_stb), .ufm_ready(ufm_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] salt = '0;
  bit   rand_gap = 1'b0;
  int   rdy_mode = 0;  // 0: stalled, 1: always ready, 2: random

  logic [7:0]  exp_q[$];
  logic [10:0] exp_addr_q[$];
  int start_cnt = 0, seen_stb = 0, done_cnt = 0, ref_cnt = 0, max_cnt = 0;
  bit ref_busy = 1'b0, exp_done = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] page_byte(logic [10:0] a, int i);
    return (a[7:0] ^ salt) + 8'(i);
  endfunction

  // Streamer model: one page of 16 strobes per accepted start.
  logic        s_busy;
  logic [10:0] s_addr;
  logic [4:0]  s_idx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_busy <= 1'b0; s_addr <= '0; s_idx <= '0;
      ufm_ready <= 1'b0; ufm_data_stb <= 1'b0; ufm_data <= '0;
    end else begin
      ufm_data_stb <= 1'b0;
      if (!s_busy) begin
        ufm_ready <= rand_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ufm_start) begin
          start_cnt++;
          chk("start_expected", exp_addr_q.size() != 0, 1);
          if (exp_addr_q.size() != 0) chk("ufm_addr", ufm_addr, exp_addr_q.pop_front());
          s_busy <= 1'b1; s_addr <= ufm_addr; s_idx <= '0; ufm_ready <= 1'b0;
        end
      end else if (!rand_gap || $urandom_range(0, 2) != 0) begin
        ufm_data     <= page_byte(s_addr, int'(s_idx));
        ufm_data_stb <= 1'b1;
        s_idx        <= s_idx + 5'd1;
        if (s_idx == 5'd15) begin
          s_busy <= 1'b0; ufm_ready <= 1'b1;
        end
      end
    end
  end

  // Reference model: expected byte stream, occupancy, busy and done timing.
  always @(negedge clk) begin
    bit popped;
    if (rst) begin
      exp_q.delete(); exp_addr_q.delete();
      ref_cnt = 0; ref_busy = 1'b0; exp_done = 1'b0;
    end else begin
      chk("done", done, exp_done);
      chk("busy", busy, ref_busy);
      chk("out_valid", out_valid, ref_cnt != 0);
      chk("count", dut.count, ref_cnt);
      chk("overflow", overflow, 0);
      if (done) done_cnt++;
      if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
      exp_done = 1'b0;
      if (req_start && !ref_busy) begin
        if (req_pages == '0) exp_done = 1'b1;
        else begin
          ref_busy = 1'b1;
          for (int k = 0; k < int'(req_pages); k++) begin
            exp_addr_q.push_back(req_addr + 11'(k));
            for (int i = 0; i < 16; i++) exp_q.push_back(page_byte(req_addr + 11'(k), i));
          end
        end
      end
      popped = (ref_cnt != 0) && out_ready;
      if (popped) begin
        ref_cnt--;
        chk("data_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("out_data", out_data, exp_q.pop_front());
          if (exp_q.size() == 0) begin exp_done = 1'b1; ref_busy = 1'b0; end
        end
      end
      if (ufm_data_stb) begin seen_stb++; ref_cnt++; end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk); #1;
      out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  endtask

  task automatic issue(logic [10:0] a, logic [11:0] p);
    req_addr = a; req_pages = p; req_start = 1'b1;
    step(1);
    req_start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin step(1); k++; end
    chk("done_seen", done_cnt != d0, 1);
    chk("stream_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_ufm_start"}, ufm_start, 0);
    chk({tag, "_ufm_addr"}, ufm_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_count"}, dut.count, 0);
  endtask

  initial begin
    int s0, d0, b0, k;
    #1 rst = 1'b1;
    #2 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(3);

    // Single page, bytes 0x00..0x0F, continuous ready
    salt = 8'h05; rdy_mode = 1; rand_gap = 1'b0; max_cnt = 0;
    step(1);
    s0 = start_cnt;
    issue(11'h005, 12'd1);
    wait_done(200);
    chk("single_starts", start_cnt - s0, 1);
    chk("pushpop_max_count", max_cnt, 1);

    // Backpressure: only two pages fit while the consumer stalls
    salt = 8'($urandom); rdy_mode = 0;
    step(1);
    s0 = start_cnt;
    issue(11'($urandom_range(0, 2047)), 12'd4);
    step(150);
    chk("bp_starts_stalled", start_cnt - s0, 2);
    chk("bp_count_full", dut.count, DEPTH);
    rdy_mode = 1;
    wait_done(500);
    chk("bp_starts_total", start_cnt - s0, 4);

    // Address wrap 0x7FF -> 0x000 with random handshakes
    salt = 8'($urandom); rdy_mode = 2; rand_gap = 1'b1;
    s0 = start_cnt;
    issue(11'h7FF, 12'd2);
    wait_done(1000);
    chk("wrap_starts", start_cnt - s0, 2);

    // Zero length: done pulse, no streamer traffic
    s0 = start_cnt; d0 = done_cnt;
    issue(11'h123, 12'd0);
    step(3);
    chk("zero_len_done", done_cnt - d0, 1);
    chk("zero_len_starts", start_cnt - s0, 0);

    // Second request while busy is ignored
    s0 = start_cnt;
    issue(11'h100, 12'd3);
    step(2);
    issue(11'h200, 12'd5);
    wait_done(2000);
    chk("busy_ignore_starts", start_cnt - s0, 3);

    // Reset after the 7th strobe of a run, then a clean run
    salt = 8'($urandom);
    issue(11'($urandom_range(0, 2047)), 12'd3);
    b0 = seen_stb; k = 0;
    while (seen_stb < b0 + 7 && k < 500) begin step(1); k++; end
    chk("rst_reach_7th", seen_stb >= b0 + 7, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrun");
    @(posedge clk); #1 rst = 1'b0;
    step(2);
    s0 = start_cnt;
    issue(11'h3F0, 12'd2);
    wait_done(1000);
    chk("post_rst_starts", start_cnt - s0, 2);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      int np;
      np = $urandom_range(1, 5);
      salt = 8'($urandom);
      s0 = start_cnt;
      issue(11'($urandom_range(0, 2047)), 12'(np));
      wait_done(3000);
      chk("rand_starts", start_cnt - s0, np);
    end

    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ufm_page_fetcher.md
# ufm_page_fetcher

Downstream consumer of the UFM streamer. It issues a run of consecutive 16-byte UFM page reads to the streamer and captures each strobed byte into an internal FIFO. It presents the bytes to user logic over a valid/ready handshake. It provides the backpressure the streamer lacks: a page read starts only when the FIFO has room for a whole page, so bytes are never dropped.

## Interface
- BUF_PAGES, 2: FIFO capacity in pages. Depth = 16*BUF_PAGES bytes. Legal values are 2 or 4, so depth is a power of two.
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high; one clock; every register clears immediately
- req_start  input  1  one-cycle pulse that starts a fetch run; ignored while busy=1
- req_addr  input  11  first UFM page address, sampled on req_start
- req_pages  input  12  number of pages to fetch (0..2048), sampled on req_start
- busy  output  1  high from the cycle after an accepted req_start until done
- done  output  1  one-cycle pulse when the run completes and the FIFO has drained
- overflow  output  1  sticky error flag; set if a byte strobe arrives with the FIFO full; cleared only by rst
- ufm_start  output  1  start request to the streamer
- ufm_addr  output  11  page address to the streamer
- ufm_data  input  8  byte from the streamer
- ufm_data_stb  input  1  byte-valid strobe from the streamer; one cycle per byte
- ufm_ready  input  1  streamer can accept start
- out_data  output  8  FIFO head byte
- out_valid  output  1  FIFO not empty
- out_ready  input  1  user consumes the head byte when out_valid & out_ready

## Operation
- States: IDLE, WAIT_SPACE, ISSUE, COLLECT, DRAIN.
- IDLE:
  - On req_start with req_pages≠0: latch ufm_addr←req_addr and pages_left←req_pages, then go to WAIT_SPACE.
  - On req_start with req_pages=0: pulse done on the next cycle and stay in IDLE; busy stays low.
- WAIT_SPACE: go to ISSUE when count ≤ DEPTH−16, where count is the number of FIFO entries.
- ISSUE:
  - ufm_start = (state==ISSUE) & ufm_ready. This is combinational so that the streamer samples it in its own IDLE state.
  - Go to COLLECT on the same cycle that ufm_start is high.
- COLLECT:
  - A 4-bit byte counter increments on each ufm_data_stb.
  - On the 16th strobe:
    - pages_left decrements.
    - ufm_addr increments modulo 2048, so 2047 wraps to 0.
    - byte counter returns to 0.
    - Next state is WAIT_SPACE if pages_left was >1, otherwise DRAIN.
- DRAIN: when count==0, pulse done for one cycle and return to IDLE.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read and write pointers that wrap naturally, plus a count of width log2(DEPTH)+1.
  - Push on ufm_data_stb.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged; data and order are preserved.
  - If a push arrives at count==DEPTH, the byte is discarded and overflow is set. This is unreachable under correct streamer behaviour.
- Strobes outside COLLECT are still pushed, but they do not advance the byte counter.
- busy = (state≠IDLE).

## Timing
- Reset values: ufm_start 0, ufm_addr 0, out_data 0, out_valid 0, busy 0, done 0, overflow 0, count 0, both pointers 0, state IDLE.
- Push latency: a byte strobed in cycle N is visible at out_data with out_valid=1 in cycle N+1, if the FIFO was empty.
- out_data is registered from the head entry and updates on the cycle after a pop, with zero bubbles. Back-to-back pops sustain 1 byte/clk.
- ufm_start is never high for more than one cycle per page. The next ufm_start cannot occur earlier than the first cycle after the 16th strobe in which ufm_ready=1 and space is available.
- done is asserted the cycle after the final pop that empties the FIFO. busy falls in the same cycle done is high.
- An asynchronous rst mid-run aborts immediately: FIFO contents are lost and no done pulse is produced. After rst release the block is in IDLE and the streamer is expected to be reset alongside it.

## Test plan
- Single page, out_ready=1: req_addr=0x005, req_pages=1, streamer model returns bytes 0x00..0x0F. Expect one ufm_start with ufm_addr=0x005, out_data 0x00..0x0F in order, done one cycle after the last pop, overflow=0.
- Backpressure, BUF_PAGES=2: req_pages=4 with out_ready=0. Expect exactly 2 ufm_start pulses (count=32) and no third. Raise out_ready: after 16 pops the third ufm_start fires, and all 64 bytes arrive in order.
- Address wrap: req_addr=0x7FF, req_pages=2. Expect ufm_addr 0x7FF then 0x000.
- Simultaneous push/pop: with count=1 and out_ready=1 during strobes, count stays at 1 and no byte is lost or duplicated.
- Zero length and busy ignore: req_pages=0 gives a done pulse with no ufm_start. A second req_start issued while busy does not change ufm_addr or pages_left.
- Reset mid-run: assert rst after the 7th strobe. Outputs return to reset values in the same cycle. A new run after release fetches correctly.
